// File: rtl/dmem_bytelane.sv
// Data memory for the MEM stage: byte/half/word loads and stores behind a req/ready handshake.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_bytelane #(
    parameter int DEPTH_WORDS = 2048,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] address,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              we_q, uns_q;
    logic [1:0]        size_q;
    logic [IDX_W+1:0]  addr_q;
    logic [31:0]       din_q;
    logic [31:0]       dout_q, dout_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_d;

    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0]  idx_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       rdata_s;
    logic [7:0]        lane_b_s;
    logic [15:0]       lane_h_s;
    logic [31:0]       load_s;
    logic              trap_s;

    assign idx_s = addr_q[IDX_W+1:2];

    // Trap detection on the latched request
    always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
        trap_s = (size_q == 2'b11) ||
                 ((size_q == 2'b01) && addr_q[0]) ||
                 ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
        trap_s = 1'b0;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // FSM next state and wait counter
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                    wcnt_d  = WCNT_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs, registered one cycle ahead so they line up with the state
    always_comb begin
        ready_d = (state_q == S_ACCESS);
        busy_d  = (state_d != S_IDLE);
        err_d   = (state_q == S_ACCESS) && trap_s;
        if ((state_q == S_ACCESS) && !we_q && !trap_s) begin
            dout_d = load_s;
        end else begin
            dout_d = dout_q;
        end
    end

    // Output registers and request capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q  <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            din_q   <= 32'd0;
        end else begin
            dout_q  <= dout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            if ((state_q == S_IDLE) && req) begin
                we_q   <= we;
                uns_q  <= uns;
                size_q <= size;
                addr_q <= address[IDX_W+1:0];
                din_q  <= din;
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q;
    // Error pulse register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    logic unused_err_s;
    assign unused_err_s = err_d;
    assign err = 1'b0;
`endif

    // Store lane enables; misaligned halves/words are forced to alignment
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = din_q;
        case (size_q)
            2'b00: begin
                be_s    = 4'b0001 << addr_q[1:0];
                wdata_s = {4{din_q[7:0]}};
            end
            2'b01: begin
                be_s    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{din_q[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = din_q;
            end
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        rdata_s = mem_q[idx_s];
        case (addr_q[1:0])
            2'b00:   lane_b_s = rdata_s[7:0];
            2'b01:   lane_b_s = rdata_s[15:8];
            2'b10:   lane_b_s = rdata_s[23:16];
            default: lane_b_s = rdata_s[31:24];
        endcase
        lane_h_s = addr_q[1] ? rdata_s[31:16] : rdata_s[15:0];
        case (size_q)
            2'b00:   load_s = {{24{~uns_q & lane_b_s[7]}}, lane_b_s};
            2'b01:   load_s = {{16{~uns_q & lane_h_s[15]}}, lane_h_s};
            default: load_s = rdata_s;
        endcase
    end

    // Storage array, not reset
    always_ff @(posedge clk) begin
        if ((state_q == S_ACCESS) && we_q && !trap_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_q[idx_s][8*k +: 8] <= wdata_s[8*k +: 8];
                end
            end
        end
    end

    assign dout  = dout_q;
    assign ready = ready_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench: two instances (0 and 3 wait states) against a byte-array reference model.
module tb_dmem_bytelane;
    localparam int DEPTH = 2048;
    localparam int WS0   = 0;
    localparam int WS3   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req3, we, uns;
    logic [1:0]  size;
    logic [31:0] address, din;
    logic [31:0] dout0, dout3;
    logic        ready0, ready3, busy0, busy3, err0, err3;

    always #5 clk = ~clk;

    dmem_bytelane #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .size(size), .uns(uns),
        .address(address), .din(din), .dout(dout0), .ready(ready0), .busy(busy0), .err(err0));

    dmem_bytelane #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .size(size), .uns(uns),
        .address(address), .din(din), .dout(dout3), .ready(ready3), .busy(busy3), .err(err3));

    typedef struct {
        int          rcyc;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        q0[$];
    exp_t        q3[$];
    exp_t        e0, e3;
    logic [7:0]  mem_m [4*DEPTH];
    logic [31:0] last_dout [2];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: byte-addressed memory, little-endian lanes
    function automatic void model_exec(input logic w, input logic [1:0] sz, input logic u,
                                       input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] ld, output logic tr);
        int nb;
        int base;
`ifdef DMEM_MISALIGN_TRAP_EN
        tr = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
        tr = 1'b0;
`endif
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a % (4 * DEPTH));
        base = base - (base % nb);
        ld   = 32'd0;
        if (!tr) begin
            if (w) begin
                for (int i = 0; i < nb; i++) mem_m[base + i] = d[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) ld[8*i +: 8] = mem_m[base + i];
                if (nb < 4 && !u && ld[8*nb - 1])
                    for (int i = nb; i < 4; i++) ld[8*i +: 8] = 8'hFF;
            end
        end
    endfunction

    task automatic push(input int k, input logic w, input logic tr, input logic [31:0] ld, input int ws);
        exp_t x;
        if (!w && !tr) last_dout[k] = ld;
        x.rcyc = cyc + 2 + ws;
        x.d    = last_dout[k];
        x.e    = tr;
        if (k == 0) q0.push_back(x);
        else        q3.push_back(x);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 80 && (q0.size() != 0 || q3.size() != 0); n++) @(negedge clk);
        if (q0.size() != 0 || q3.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: pending %0d/%0d expected 0/0", q0.size(), q3.size());
            q0.delete();
            q3.delete();
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ld;
        logic        tr;
        @(negedge clk);
        we = w; size = sz; uns = u; address = a; din = d;
        model_exec(w, sz, u, a, d, ld, tr);
        push(0, w, tr, ld, WS0);
        push(1, w, tr, ld, WS3);
        req0 = 1'b1;
        req3 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        req3 = 1'b0;
        wait_idle();
    endtask

    // Monitors: pop and compare whenever a DUT signals completion
    always @(negedge clk) begin
        if (ready0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready0: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("latency0", cyc, e0.rcyc);
                chk("dout0", dout0, e0.d);
                chk("err0", {31'd0, err0}, {31'd0, e0.e});
                chk("busy0", {31'd0, busy0}, 32'd1);
            end
        end
        if (ready3) begin
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready3: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e3 = q3.pop_front();
                chk("latency3", cyc, e3.rcyc);
                chk("dout3", dout3, e3.d);
                chk("err3", {31'd0, err3}, {31'd0, e3.e});
                chk("busy3", {31'd0, busy3}, 32'd1);
            end
        end
    end

    initial begin
        logic [31:0] ld;
        logic        tr;
        int          c;
        rst = 1'b1; req0 = 1'b0; req3 = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0;
        address = 32'd0; din = 32'd0;
        last_dout[0] = 32'd0;
        last_dout[1] = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_dout0", dout0, 32'd0);
        chk("rst_dout3", dout3, 32'd0);
        chk("rst_flags0", {29'd0, ready0, busy0, err0}, 32'd0);
        chk("rst_flags3", {29'd0, ready3, busy3, err3}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) issue(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        chk("tp_word", dout0, 32'hDEADBEEF);
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000080);
        issue(1'b0, 2'd0, 1'b0, 32'h11, 32'd0);
        chk("tp_byte_s", dout0, 32'hFFFFFF80);
        issue(1'b0, 2'd0, 1'b1, 32'h11, 32'd0);
        chk("tp_byte_u", dout3, 32'h00000080);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        chk("tp_word_merge", dout0, 32'hDEAD80EF);
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        chk("tp_half_upper", {16'd0, dout0[31:16]}, 32'h00001234);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'd0);
        chk("tp_half_load", dout0, 32'h00001234);
        issue(1'b1, 2'd2, 1'b0, 32'h2004, 32'h5A5AA5A5);
        issue(1'b0, 2'd2, 1'b0, 32'h0004, 32'd0);
        chk("tp_wrap", dout3, 32'h5A5AA5A5);
        issue(1'b1, 2'd2, 1'b0, 32'h13, 32'h11223344);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("tp_misalign_trap", dout0, 32'hDEAD80EF);
`else
        chk("tp_misalign_force", dout0, 32'h11223344);
`endif

        for (int i = 0; i < 300; i++)
            issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom & 32'hFFFF_E0FF, $urandom);

        // Request held high on the 3-wait-state instance: second acceptance only after DONE
        @(negedge clk);
        we = 1'b0; size = 2'd2; uns = 1'b0; address = 32'h10;
        model_exec(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, ld, tr);
        c = cyc;
        push(1, 1'b0, tr, ld, WS3);
        q3[0].rcyc = c + 5;
        push(1, 1'b0, tr, ld, WS3);
        q3[1].rcyc = c + 11;
        req3 = 1'b1;
        repeat (7) @(negedge clk);
        req3 = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        // Reset during WAIT abandons the store
        we = 1'b1; size = 2'd2; address = 32'h10; din = 32'hCAFEF00D;
        req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        @(negedge clk);
        chk("busy_in_wait", {31'd0, busy3}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait_dout", dout3, 32'd0);
        chk("rst_wait_flags", {29'd0, ready3, busy3, err3}, 32'd0);
        last_dout[0] = 32'd0;
        last_dout[1] = 32'd0;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        repeat (5) @(negedge clk);
        chk("idle_busy0", {31'd0, busy0}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised data memory for the pipelined MIPS core's MEM stage. It replaces the fixed 8 KB, word-only, single-cycle data memory. It adds byte, halfword and word loads and stores with sign/zero extension, a configurable number of wait states behind a req/ready handshake, and optional misalignment trapping. The pipeline stalls on `busy` and samples load data on `ready`.

## Interface
Parameters:
- `DEPTH_WORDS`, 2048: number of 32-bit words; power of two, at least 16. `IDX_W = clog2(DEPTH_WORDS)`.
- `WAIT_STATES`, 0: extra cycles inserted before the array access; range 0–15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  access request; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `uns`  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- `address`  in  32  byte address.
- `din`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `dout`  out  32  load result; holds its value until the next completed load.
- `ready`  out  1  one-cycle pulse when an access completes.
- `busy`  out  1  high from the cycle after `req` is accepted until `ready`, inclusive.
- `err`  out  1  one-cycle pulse together with `ready` when an access is trapped.

## Operation
- Storage is `DEPTH_WORDS` × 32 bits. Word index is `address[IDX_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`. The array is not cleared by reset.
- Lanes are little-endian: byte offset k = `address[1:0]` maps to bits [8k+7:8k]. A halfword at offset 0 uses [15:0]; at offset 2 it uses [31:16].
- Stores write only the addressed lanes; the other lanes keep their contents.
- Loads extract the addressed lane(s) into `dout` bits [7:0] or [15:0]. The upper bits are filled with zeros when `uns`=1, or with copies of the lane's top bit when `uns`=0. Word loads ignore `uns`.
- FSM states:
  - IDLE: if `req`=1, latch `we`, `size`, `uns`, `address` and `din`. Go to WAIT if `WAIT_STATES`>0, otherwise go to ACCESS.
  - WAIT: decrement a counter loaded with `WAIT_STATES`-1. Go to ACCESS when the counter reaches 0.
  - ACCESS: perform the array write, or read and format into `dout`. Go to DONE.
  - DONE: assert `ready`=1 for one cycle, then return to IDLE.
- `req` is ignored outside IDLE. A new request can be accepted in the cycle after DONE.
- Reset values: state IDLE, `dout`=0, `ready`=0, `busy`=0, `err`=0, wait counter 0.
- Reset during WAIT: the access is abandoned and memory is unchanged.
- Reset asserted at the ACCESS edge: the write may or may not commit. Software must not rely on either outcome.

## Timing
- Latency: `req` accepted at edge N gives `ready` high during cycle N+2+`WAIT_STATES`. With `WAIT_STATES`=0 that is 2 cycles.
- `dout` is valid from the `ready` cycle onward. It is unchanged by stores and by trapped accesses.
- Stored data is visible to a load accepted in or after the store's `ready` cycle.
- `busy` is registered and rises the cycle after acceptance, so the pipeline must stall on `req & ~ready` combined with `busy`.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: the following are trapped and never reach the array:
  - halfword with `address[0]`=1;
  - word with `address[1:0]`≠0;
  - any access with `size`=11.
  
  A trapped access still passes through every FSM state. In DONE it gives `ready`=1 and `err`=1, with no write and no change to `dout`.
- `DMEM_MISALIGN_TRAP_EN` undefined: `err` is tied to 0.
  - Misaligned halfwords are forced to alignment (`address[0]` treated as 0).
  - Misaligned words are forced to alignment (`address[1:0]` treated as 0).
  - `size`=11 is treated as a word access.

## Test plan
- Reset, then word store 0xDEADBEEF to 0x10 and word load from 0x10 → `ready` 2 cycles after each `req`, `dout`=0xDEADBEEF, `err`=0.
- Byte store 0x80 to 0x11, then byte load from 0x11 with `uns`=0 → `dout`=0xFFFFFF80. Same load with `uns`=1 → 0x00000080. Word at 0x10 reads 0xDEAD80EF.
- Halfword store 0x1234 to 0x22, then word load from 0x20 → upper half 0x1234, lower half unchanged. Halfword load from 0x22 with `uns`=0 → 0x00001234.
- `WAIT_STATES`=3: `req` accepted at edge N → `ready` in cycle N+5. A second `req` held high throughout is accepted only after DONE.
- With `DEPTH_WORDS`=2048, store to address 0x2004, then load from 0x0004 → the stored value (wrap-around).
- `DMEM_MISALIGN_TRAP_EN` defined: word store to 0x13 → `ready`=1 and `err`=1; word 0x10 unchanged. Undefined: the same store writes word 0x10 and `err`=0.
